// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [2:0] {ARB, HOLD, ISSUE, WAIT_HI, WAIT_LO} arb_state_t;

  localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Rotate-priority picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin sharing of one uart_tx among NUM_REQ byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 4095
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           send_trig,
  output logic [UART_BYTE_W-1:0]         send_data,
  input  logic                           tx_bsy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           locked,
  output logic                           timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(IDLE_TIMEOUT);

  arb_state_t             state_q, state_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   last_q, last_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic                   locked_q, locked_d;
  logic                   to_q, to_d;
  logic [CW-1:0]          idle_q, idle_d;
  logic                   whi_q, whi_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [GW-1:0]          arb_idx;
  logic                   arb_any;
  logic [GW-1:0]          ptr_next;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign ptr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    locked_d  = locked_q;
    to_d      = 1'b0;
    idle_d    = idle_q;
    whi_d     = whi_q;
    req_ready = '0;
    send_trig = 1'b0;
    unique case (state_q)
      ARB: begin
        // rst_n gate keeps ready low while reset holds state in ARB
        if (rst_n && !tx_bsy && arb_any) begin
          req_ready = arb_gnt;
          data_d    = req_data[arb_idx*UART_BYTE_W +: UART_BYTE_W];
          last_d    = req_last[arb_idx];
          grant_d   = arb_idx;
          locked_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        send_trig = 1'b1;
        whi_d     = 1'b0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_bsy) state_d = WAIT_LO;
        else if (whi_q) state_d = ISSUE;
        else whi_d = 1'b1;
      end
      WAIT_LO: begin
        if (!tx_bsy) begin
          if (last_q) begin
            locked_d = 1'b0;
            ptr_d    = ptr_next;
            state_d  = ARB;
          end else begin
            idle_d  = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_valid[grant_q]) begin
          req_ready[grant_q] = 1'b1;
          data_d  = req_data[grant_q*UART_BYTE_W +: UART_BYTE_W];
          last_d  = req_last[grant_q];
          state_d = ISSUE;
        end else begin
          if (idle_q != '1) idle_d = idle_q + 1'b1;
          if (IDLE_TIMEOUT != 0 && idle_d == TO_VAL) begin
            to_d     = 1'b1;
            locked_d = 1'b0;
            ptr_d    = ptr_next;
            state_d  = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      data_q   <= '0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      ptr_q    <= '0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
      idle_q   <= '0;
      whi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      to_q     <= to_d;
      idle_q   <= idle_d;
      whi_q    <= whi_d;
    end
  end

  assign send_data   = data_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter with a behavioural uart_tx and round-robin packet model.
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int TO      = 64;
  localparam int BIT_CYC = 27;
  localparam int FRAME   = 10 * BIT_CYC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*8-1:0] req_data;
  logic            send_trig;
  logic [7:0]      send_data;
  logic            tx_bsy, bsy_m, force_bsy;
  logic [1:0]      grant_id;
  logic            locked, timeout_err;

  logic [8:0] srcq [NR][$];
  logic [8:0] mq   [NR][$];
  logic [7:0] wire_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sh;

  int errors = 0, checks = 0, cyc = 0, tick = 0, drop_trigs = 0;
  int to_cnt = 0, to_cyc = 0;
  int rdy_cnt[NR];
  int take_wire[NR];

  always #5 clk = ~clk;

  assign tx_bsy = bsy_m | force_bsy;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .send_trig(send_trig),
    .send_data(send_data), .tx_bsy(tx_bsy), .grant_id(grant_id),
    .locked(locked), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int i, input logic last, input logic [7:0] d);
    srcq[i].push_back({last, d});
    mq[i].push_back({last, d});
  endtask

  // Whole packets go to the first non-empty requester at or after the pointer.
  task automatic build_expect(input int ptr, output int end_ptr);
    int p;
    logic [8:0] e;
    p = ptr;
    exp_q.delete();
    forever begin
      int o;
      o = -1;
      for (int k = 0; k < NR; k++)
        if (o < 0 && mq[(p + k) % NR].size() > 0) o = (p + k) % NR;
      if (o < 0) break;
      do begin
        e = mq[o].pop_front();
        exp_q.push_back(e[7:0]);
      end while (!e[8]);
      p = (o + 1) % NR;
    end
    end_ptr = p;
  endtask

  task automatic wait_wire(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wire_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(wire_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wire_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Requesters: present queue head, pop on a transfer seen mid-cycle.
  initial begin : drv
    logic [NR-1:0] take;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      take = req_valid & req_ready;
      for (int i = 0; i < NR; i++)
        if (take[i]) begin
          rdy_cnt[i]++;
          take_wire[i] = wire_q.size();
        end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (take[i]) void'(srcq[i].pop_front());
        req_valid[i]       = srcq[i].size() > 0;
        req_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0][7:0] : 8'h00;
        req_last[i]        = (srcq[i].size() > 0) ? srcq[i][0][8] : 1'b0;
      end
    end
  end

  // uart_tx stand-in: busy from the cycle after the trigger for one 10-bit frame.
  initial begin : uart
    logic trig, rn;
    logic [7:0] d;
    bsy_m = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      trig = send_trig; d = send_data; rn = rst_n;
      #1;
      if (!rn) begin
        bsy_m = 1'b0; tick = 0;
      end else if (bsy_m) begin
        tick++;
        if (tick == FRAME) begin
          bsy_m = 1'b0;
          wire_q.push_back(sh);
        end
      end else if (trig) begin
        if (drop_trigs > 0) drop_trigs--;
        else begin
          sh = d; bsy_m = 1'b1; tick = 0;
        end
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      checks++;
      assert (((req_ready & ~req_valid) == '0) && $onehot0(req_ready)) else begin
        errors++;
        $error("FAIL ready_legal: observed ready=%b valid=%b expected onehot0 subset", req_ready, req_valid);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    int fall, k, endp, total, bad;
    logic [7:0] b;
    force_bsy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_trig", 32'(send_trig), 0);
    chk("rst_data", 32'(send_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte from idle, latency
    put(0, 1'b1, 8'hA5);
    void'(mq[0].pop_front());
    @(negedge clk);
    chk("t1_ready_c0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("t1_trig_c1", 32'(send_trig), 1);
    chk("t1_data_c1", 32'(send_data), 32'hA5);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_grant", 32'(grant_id), 0);
    @(negedge clk);
    chk("t1_bsy_c2", 32'(tx_bsy), 1);
    wait_wire("t1_wait", 1, FRAME + 20);
    chk("t1_wire", 32'(wire_q[0]), 32'hA5);
    chk("t1_locked_hold", 32'(locked), 1);
    @(negedge clk);
    chk("t1_unlock", 32'(locked), 0);

    // 2: packet lock keeps req2 out until 0x33 is done
    wire_q.delete();
    put(1, 1'b0, 8'h11); put(1, 1'b0, 8'h22); put(1, 1'b1, 8'h33);
    put(2, 1'b1, 8'h44);
    build_expect(1, endp);
    wait_wire("t2_wait", 4, 4 * (FRAME + 20));
    for (int i = 0; i < 4; i++) chk($sformatf("t2_wire%0d", i), 32'(wire_q[i]), 32'(exp_q[i]));
    chk("t2_ready2_after33", 32'(take_wire[2]), 3);
    chk("t2_grant", 32'(grant_id), 2);

    // 3: all requesters contend with one-byte packets from pointer 0
    do_reset();
    put(0, 1'b1, 8'h00); put(1, 1'b1, 8'h01); put(2, 1'b1, 8'h02);
    put(3, 1'b1, 8'h03); put(0, 1'b1, 8'h00); put(1, 1'b1, 8'h01);
    build_expect(0, endp);
    wait_wire("t3_wait", 6, 6 * (FRAME + 20));
    for (int i = 0; i < 6; i++) chk($sformatf("t3_wire%0d", i), 32'(wire_q[i]), 32'(exp_q[i]));
    chk("t3_wrap", 32'(wire_q[4]), 32'h00);

    // 4: owner goes idle mid-packet; timeout releases to waiting req0
    repeat (2) @(negedge clk);
    wire_q.delete();
    k = rdy_cnt[3];
    srcq[3].push_back({1'b0, 8'h7E});
    while (rdy_cnt[3] == k && k < 1000) begin @(negedge clk); k = k + 0; end
    srcq[0].push_back({1'b1, 8'hC3});
    wait_wire("t4_wait7e", 1, FRAME + 20);
    fall = cyc;
    chk("t4_wire0", 32'(wire_q[0]), 32'h7E);
    k = 0;
    while (to_cnt == 0 && k < 200) begin @(negedge clk); k++; end
    chk("t4_to_delay", 32'(to_cyc - fall), 32'(TO + 1));
    wait_wire("t4_waitc3", 2, FRAME + 40);
    chk("t4_wire1", 32'(wire_q[1]), 32'hC3);
    chk("t4_to_once", 32'(to_cnt), 1);
    chk("t4_grant", 32'(grant_id), 0);

    // 5: reset during data bit 3 of req1's frame
    repeat (2) @(negedge clk);
    wire_q.delete();
    srcq[1].push_back({1'b0, 8'h5A});
    srcq[1].push_back({1'b1, 8'h5B});
    k = 0;
    while (!(bsy_m && tick == 4 * BIT_CYC + BIT_CYC / 2) && k < 400) begin @(negedge clk); k++; end
    chk("t5_reached_bit3", 32'(bsy_m), 1);
    rst_n = 1'b0;
    srcq[3].push_back({1'b1, 8'h3C});
    #1;
    chk("t5_rst_trig", 32'(send_trig), 0);
    chk("t5_rst_data", 32'(send_data), 0);
    chk("t5_rst_grant", 32'(grant_id), 0);
    chk("t5_rst_locked", 32'(locked), 0);
    chk("t5_rst_timeout", 32'(timeout_err), 0);
    repeat (3) @(negedge clk);
    chk("t5_rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    wait_wire("t5_wait", 2, 2 * (FRAME + 20));
    chk("t5_wire0", 32'(wire_q[0]), 32'h5B);
    chk("t5_wire1", 32'(wire_q[1]), 32'h3C);

    // 6: UART busy at reset release blocks the grant
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    force_bsy = 1'b1;
    srcq[2].push_back({1'b1, 8'h6C});
    repeat (2) @(negedge clk);
    wire_q.delete();
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0 || send_trig) bad++;
    end
    chk("t6_blocked", 32'(bad), 0);
    @(posedge clk); #2;
    force_bsy = 1'b0;
    @(negedge clk);
    chk("t6_ready2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    chk("t6_trig", 32'(send_trig), 1);
    chk("t6_data", 32'(send_data), 32'h6C);
    wait_wire("t6_wait", 1, FRAME + 20);
    chk("t6_wire", 32'(wire_q[0]), 32'h6C);

    // Randomized packets, two rounds; first trigger of round 0 is swallowed.
    do_reset();
    endp = 0;
    for (int r = 0; r < 2; r++) begin
      wire_q.delete();
      if (r == 0) drop_trigs = 1;
      for (int i = 0; i < NR; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            b = 8'($urandom);
            put(i, j == len - 1, b);
          end
        end
      end
      build_expect(endp, endp);
      total = exp_q.size();
      wait_wire($sformatf("rnd%0d_wait", r), total, (total + 2) * (FRAME + 20));
      repeat (FRAME + 20) @(negedge clk);
      chk($sformatf("rnd%0d_count", r), 32'(wire_q.size()), 32'(total));
      for (int i = 0; i < total; i++)
        chk($sformatf("rnd%0d_b%0d", r, i), 32'(wire_q[i]), 32'(exp_q[i]));
      chk($sformatf("rnd%0d_unlocked", r), 32'(locked), 0);
    end
    chk("rnd_retrigger_used", 32'(drop_trigs), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
